// File: rtl/pipe_hazard_ctrl.sv
// RV32I pipeline interlock: tracks in-flight destinations, forwards or stalls on RAW hazards,
// flushes ID on taken jumps, and sequences fence.i (drain + I-side invalidate) and wfi sleep.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter bit          FWD_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] inst_rs1,
    input  logic [4:0] inst_rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       id_wbk,
    input  logic [4:0] id_rd,
    input  logic       id_is_ld,
    input  logic       id_fencei,
    input  logic       id_wfi,
    input  logic       ex_jmp_taken,
    input  logic       irq_pend,
    input  logic       fencei_ack,
    output logic       stall_ld,
    output logic       flush_id,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       fencei_req,
    output logic       sleeping
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        SLEEP = 2'd3
    } state_e;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       resume_q, resume_d;

    // Only the EX entry needs the load flag: load-use is resolved the moment the load leaves EX.
    logic       ex_v_q, ex_v_d;
    logic       ex_wbk_q, ex_wbk_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_ld_q, ex_ld_d;
    logic       ma_v_q, ma_wbk_q;
    logic [4:0] ma_rd_q;
    logic       wb_v_q, wb_wbk_q;
    logic [4:0] wb_rd_q;

    function automatic logic hit(input logic v, input logic wbk, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic used);
        return v & wbk & (rd != 5'd0) & (rd == rs) & used;
    endfunction

    function automatic logic [1:0] fwdSel(input logic hitEx, input logic hitMa, input logic hitWb);
        if (hitEx) return 2'd1;
        if (hitMa) return 2'd2;
        if (hitWb) return 2'd3;
        return 2'd0;
    endfunction

    logic ex_hit1, ma_hit1, wb_hit1;
    logic ex_hit2, ma_hit2, wb_hit2;
    logic raw_any, ld_use, raw_stall;
    logic issue_ok, start_fencei, start_wfi;

    assign ex_hit1 = hit(ex_v_q, ex_wbk_q, ex_rd_q, inst_rs1, rs1_used);
    assign ma_hit1 = hit(ma_v_q, ma_wbk_q, ma_rd_q, inst_rs1, rs1_used);
    assign wb_hit1 = hit(wb_v_q, wb_wbk_q, wb_rd_q, inst_rs1, rs1_used);
    assign ex_hit2 = hit(ex_v_q, ex_wbk_q, ex_rd_q, inst_rs2, rs2_used);
    assign ma_hit2 = hit(ma_v_q, ma_wbk_q, ma_rd_q, inst_rs2, rs2_used);
    assign wb_hit2 = hit(wb_v_q, wb_wbk_q, wb_rd_q, inst_rs2, rs2_used);

    assign raw_any   = id_valid & (ex_hit1 | ma_hit1 | wb_hit1 | ex_hit2 | ma_hit2 | wb_hit2);
    assign ld_use    = id_valid & ex_ld_q & (ex_hit1 | ex_hit2);
    assign raw_stall = FWD_EN ? ld_use : raw_any;

    // A taken jump kills the ID instruction, so holding it would be pointless.
    assign flush_id    = ex_jmp_taken;
    assign stall_ld    = (raw_stall | (state_q != RUN)) & ~flush_id;
    assign fwd_rs1_sel = FWD_EN ? fwdSel(ex_hit1, ma_hit1, wb_hit1) : 2'd0;
    assign fwd_rs2_sel = FWD_EN ? fwdSel(ex_hit2, ma_hit2, wb_hit2) : 2'd0;
    assign fencei_req  = (state_q == FLUSH);
    assign sleeping    = (state_q == SLEEP);

    // resume_q marks the first RUN cycle after a sequence, when the same fence.i/wfi is still
    // in ID and must pass into EX instead of restarting the sequence.
    assign issue_ok     = (state_q == RUN) & id_valid & ~flush_id & ~stall_ld & ~resume_q;
    assign start_fencei = issue_ok & id_fencei;
    assign start_wfi    = issue_ok & id_wfi & ~id_fencei;

    always_comb begin
        ex_v_d   = id_valid & ~stall_ld & ~flush_id & (state_q == RUN) & ~start_fencei & ~start_wfi;
        ex_wbk_d = id_wbk;
        ex_rd_d  = id_rd;
        ex_ld_d  = id_is_ld;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resume_d = 1'b0;
        case (state_q)
            RUN: begin
                if (start_fencei) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (start_wfi) begin
                    state_d = SLEEP;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fencei_ack) begin
                    state_d  = RUN;
                    resume_d = 1'b1;
                end
            end
            SLEEP: begin
                if (irq_pend) begin
                    state_d  = RUN;
                    resume_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= 3'd0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q   <= 1'b0;
            ex_wbk_q <= 1'b0;
            ex_rd_q  <= 5'd0;
            ex_ld_q  <= 1'b0;
            ma_v_q   <= 1'b0;
            ma_wbk_q <= 1'b0;
            ma_rd_q  <= 5'd0;
            wb_v_q   <= 1'b0;
            wb_wbk_q <= 1'b0;
            wb_rd_q  <= 5'd0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_wbk_q <= ex_wbk_d;
            ex_rd_q  <= ex_rd_d;
            ex_ld_q  <= ex_ld_d;
            ma_v_q   <= ex_v_q;
            ma_wbk_q <= ex_wbk_q;
            ma_rd_q  <= ex_rd_q;
            wb_v_q   <= ma_v_q;
            wb_wbk_q <= ma_wbk_q;
            wb_rd_q  <= ma_rd_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued as each step is driven and
// popped at the following falling edge for comparison.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] inst_rs1;
    logic [4:0] inst_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       id_wbk;
    logic [4:0] id_rd;
    logic       id_is_ld;
    logic       id_fencei;
    logic       id_wfi;
    logic       ex_jmp_taken;
    logic       irq_pend;
    logic       fencei_ack;
    logic       stall_ld;
    logic       flush_id;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;
    logic       fencei_req;
    logic       sleeping;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic       flush;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       req;
        logic       slp;
    } exp_t;

    exp_t expQ[$];

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .id_wbk(id_wbk), .id_rd(id_rd),
        .id_is_ld(id_is_ld), .id_fencei(id_fencei), .id_wfi(id_wfi), .ex_jmp_taken(ex_jmp_taken),
        .irq_pend(irq_pend), .fencei_ack(fencei_ack), .stall_ld(stall_ld), .flush_id(flush_id),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .fencei_req(fencei_req),
        .sleeping(sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string name, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic st, input logic fl, input logic [1:0] s1,
                              input logic [1:0] s2, input logic rq, input logic sl);
        exp_t e;
        e.tag = tag; e.stall = st; e.flush = fl; e.sel1 = s1; e.sel2 = s2; e.req = rq; e.slp = sl;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = expQ.pop_front();
        cmp({e.tag, ".stall_ld"}, {1'b0, stall_ld}, {1'b0, e.stall});
        cmp({e.tag, ".flush_id"}, {1'b0, flush_id}, {1'b0, e.flush});
        cmp({e.tag, ".fwd_rs1_sel"}, fwd_rs1_sel, e.sel1);
        cmp({e.tag, ".fwd_rs2_sel"}, fwd_rs2_sel, e.sel2);
        cmp({e.tag, ".fencei_req"}, {1'b0, fencei_req}, {1'b0, e.req});
        cmp({e.tag, ".sleeping"}, {1'b0, sleeping}, {1'b0, e.slp});
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic fl, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic rq, input logic sl);
        pushExpect(tag, st, fl, s1, s2, rq, sl);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; inst_rs1 = 5'd0; inst_rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        id_wbk = 1'b0; id_rd = 5'd0; id_is_ld = 1'b0; id_fencei = 1'b0; id_wfi = 1'b0;
        ex_jmp_taken = 1'b0; fencei_ack = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic wbk, input logic ld, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2, input logic u2);
        idle();
        id_valid = 1'b1; id_rd = rd; id_wbk = wbk; id_is_ld = ld;
        inst_rs1 = rs1; rs1_used = u1; inst_rs2 = rs2; rs2_used = u2;
    endtask

    initial begin
        idle();
        irq_pend = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        applyStimulus("reset", 0, 0, 0, 0, 0, 0);
        nextCycle(); rst_n = 1'b1;
        applyStimulus("postReset", 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then MA forwarding; the add behind it forwards from EX, lw from WB
        nextCycle(); instr(5, 1, 1, 1, 1, 0, 0);   applyStimulus("lwX5", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(6, 1, 0, 5, 1, 7, 1);   applyStimulus("ldUseStall", 1, 0, 1, 0, 0, 0);
        nextCycle();                               applyStimulus("ldUseFwd", 0, 0, 2, 0, 0, 0);
        nextCycle(); instr(9, 0, 0, 6, 1, 5, 1);   applyStimulus("exWbFwd", 0, 0, 1, 3, 0, 0);

        // addi x3 followed by rs2 consumers at distance 1..4, then an x0 producer
        nextCycle(); instr(3, 1, 0, 6, 1, 0, 0);   applyStimulus("addiX3", 0, 0, 2, 0, 0, 0);
        nextCycle(); instr(10, 1, 0, 0, 0, 3, 1);  applyStimulus("rs2Ex", 0, 0, 0, 1, 0, 0);
        nextCycle(); instr(11, 1, 0, 0, 0, 3, 1);  applyStimulus("rs2Ma", 0, 0, 0, 2, 0, 0);
        nextCycle(); instr(12, 1, 0, 0, 0, 3, 1);  applyStimulus("rs2Wb", 0, 0, 0, 3, 0, 0);
        nextCycle(); instr(13, 1, 0, 0, 0, 3, 1);  applyStimulus("rs2None", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(0, 1, 0, 0, 0, 0, 0);   applyStimulus("addiX0", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(0, 0, 0, 0, 1, 0, 1);   applyStimulus("x0Ex", 0, 0, 0, 0, 0, 0);
        nextCycle();                               applyStimulus("x0Ma", 0, 0, 0, 0, 0, 0);
        nextCycle();                               applyStimulus("x0Wb", 0, 0, 0, 0, 0, 0);

        // x4 live in both EX and WB: EX must win; unused operands never forward
        nextCycle(); instr(4, 1, 0, 0, 0, 0, 0);   applyStimulus("x4First", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(14, 0, 0, 0, 0, 0, 0);  applyStimulus("filler", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(4, 1, 0, 4, 1, 0, 0);   applyStimulus("x4Second", 0, 0, 2, 0, 0, 0);
        nextCycle(); instr(15, 0, 0, 4, 1, 4, 1);  applyStimulus("exWins", 0, 0, 1, 1, 0, 0);
        nextCycle(); instr(15, 0, 0, 4, 0, 4, 0);  applyStimulus("unusedRs", 0, 0, 0, 0, 0, 0);

        // Load-use coinciding with a taken jump: flush wins and EX receives a bubble
        nextCycle(); instr(8, 1, 1, 0, 0, 0, 0);   applyStimulus("lwX8", 0, 0, 0, 0, 0, 0);
        nextCycle(); instr(9, 1, 0, 8, 1, 0, 0); ex_jmp_taken = 1'b1;
        applyStimulus("flushBeatsStall", 0, 1, 1, 0, 0, 0);
        nextCycle(); instr(16, 0, 0, 9, 1, 8, 1);  applyStimulus("bubbleAfterFlush", 0, 0, 0, 2, 0, 0);
        nextCycle(); idle();                       applyStimulus("idle", 0, 0, 0, 0, 0, 0);

        // fence.i: 3 drain cycles, then request held until the ack 5 cycles after it rises
        nextCycle(); idle(); id_valid = 1'b1; id_fencei = 1'b1;
        applyStimulus("fenceiIssue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); applyStimulus("drain", 1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 6; i++) begin
            nextCycle(); fencei_ack = (i == 5);
            applyStimulus("fenceiReq", 1, 0, 0, 0, 1, 0);
        end
        nextCycle(); fencei_ack = 1'b0;            applyStimulus("fenceiResume", 0, 0, 0, 0, 0, 0);
        nextCycle(); idle();                       applyStimulus("afterFencei", 0, 0, 0, 0, 0, 0);

        // wfi with the interrupt arriving 10 cycles after issue
        nextCycle(); idle(); id_valid = 1'b1; id_wfi = 1'b1;
        applyStimulus("wfiIssue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            nextCycle(); irq_pend = (i == 9);
            applyStimulus("sleep", 1, 0, 0, 0, 0, 1);
        end
        nextCycle(); irq_pend = 1'b0;              applyStimulus("wake", 0, 0, 0, 0, 0, 0);
        nextCycle(); idle();                       applyStimulus("afterWake", 0, 0, 0, 0, 0, 0);

        // wfi with the interrupt already pending: exactly one sleep cycle
        nextCycle(); idle(); id_valid = 1'b1; id_wfi = 1'b1; irq_pend = 1'b1;
        applyStimulus("wfiIrqHigh", 0, 0, 0, 0, 0, 0);
        nextCycle();                               applyStimulus("singleSleep", 1, 0, 0, 0, 0, 1);
        nextCycle(); idle(); irq_pend = 1'b0;      applyStimulus("wakeSingle", 0, 0, 0, 0, 0, 0);

        // Reset pulse during SLEEP clears sleeping without waiting for a clock
        nextCycle(); idle(); id_valid = 1'b1; id_wfi = 1'b1;
        applyStimulus("wfiRst", 0, 0, 0, 0, 0, 0);
        nextCycle();                               applyStimulus("sleepRst", 1, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        pushExpect("asyncRstSleep", 0, 0, 0, 0, 0, 0);
        #1 checkOutput();
        nextCycle(); rst_n = 1'b1; idle();         applyStimulus("postRstRun", 0, 0, 0, 0, 0, 0);
        nextCycle();                               applyStimulus("stillRun", 0, 0, 0, 0, 0, 0);

        // Reset pulse during FLUSH drops fencei_req immediately
        nextCycle(); idle(); id_valid = 1'b1; id_fencei = 1'b1;
        applyStimulus("fenceiRst", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); applyStimulus("drainRst", 1, 0, 0, 0, 0, 0);
        end
        nextCycle();                               applyStimulus("flushBeforeRst", 1, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        pushExpect("asyncRstReq", 0, 0, 0, 0, 0, 0);
        #1 checkOutput();
        nextCycle(); rst_n = 1'b1; idle();         applyStimulus("postRstReq", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
